// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : 4-digit common-anode 7-segment scan driver, format "XX.XX",
//            frame-coherent input snapshot. Option: LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] seg0,
  input  logic [3:0] seg1,
  input  logic [3:0] seg2,
  input  logic [3:0] seg3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [CNT_W-1:0] c_TC = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_snap0, r_snap1, r_snap2, r_snap3;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_tc;
  logic [3:0]       w_digit;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;

  // Active-low gfedcba; anything outside 0..9 renders as a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = 7'b0111111;
    endcase
  endfunction

  assign w_tc = (r_cnt == c_TC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_snap0 <= 4'd0;
      r_snap1 <= 4'd0;
      r_snap2 <= 4'd0;
      r_snap3 <= 4'd0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
      // All four digits are latched together at the frame boundary to avoid tearing.
      if (r_idx == 2'd3) begin
        r_snap0 <= seg0;
        r_snap1 <= seg1;
        r_snap2 <= seg2;
        r_snap3 <= seg3;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_digit   = r_snap0;
    w_an_nxt  = 4'b1110;
    case (r_idx)
      2'd0: begin w_digit = r_snap0; w_an_nxt = 4'b1110; end
      2'd1: begin w_digit = r_snap1; w_an_nxt = 4'b1101; end
      2'd2: begin w_digit = r_snap2; w_an_nxt = 4'b1011; end
      default: begin w_digit = r_snap3; w_an_nxt = 4'b0111; end
    endcase
    w_seg_nxt = f_decode(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
    if ((r_idx == 2'd3) && (r_snap3 == 4'd0)) begin
      w_seg_nxt = 7'b1111111;
    end
`endif
    w_dp_nxt  = (r_idx != 2'd2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Scoreboard bench for seg7_scan_driver (REFRESH_DIV=4, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  localparam int c_RD = 4;

  logic       clk;
  logic       reset;
  logic [3:0] seg0, seg1, seg2, seg3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  logic [11:0] r_expq[$];
  int          n_pass;
  int          n_total;

  seg7_scan_driver #(.REFRESH_DIV(c_RD), .CNT_W(2)) dut (
    .clk  (clk),
    .reset(reset),
    .seg0 (seg0),
    .seg1 (seg1),
    .seg2 (seg2),
    .seg3 (seg3),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] f_ref_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Push expected {an,seg,dp} for the first n cycles of a frame showing d3..d0.
  task automatic push_frame(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0,
                            input int n);
    logic [3:0] d;
    logic [3:0] a;
    logic [6:0] s;
    for (int c = 0; c < n; c++) begin
      case (c / c_RD)
        0: begin d = d0; a = 4'b1110; end
        1: begin d = d1; a = 4'b1101; end
        2: begin d = d2; a = 4'b1011; end
        default: begin d = d3; a = 4'b0111; end
      endcase
      s = f_ref_seg(d);
`ifdef LEADING_ZERO_BLANK_EN
      if ((c / c_RD) == 3 && d == 4'd0) s = 7'h7F;
`endif
      r_expq.push_back({a, s, ((c / c_RD) == 2) ? 1'b0 : 1'b1});
    end
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed an/seg/dp=%b_%b_%b expected %b_%b_%b",
                tag, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
  endtask

  // Compare n cycles of DUT output against the scoreboard, sampled at negedge.
  task automatic run_check(input string tag, input int n);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (r_expq.size() == 0) begin
        n_total++;
        $error("FAIL %s: scoreboard empty at cycle %0d, observed %b_%b_%b expected entry",
               tag, i, an, seg, dp);
      end else begin
        e = r_expq.pop_front();
        check($sformatf("%s[%0d]", tag, i), {an, seg, dp}, e);
      end
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    {seg3, seg2, seg1, seg0} = 16'h0000;

    // Reset holds everything dark.
    repeat (3) begin
      @(negedge clk);
      check("reset_dark", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
    end

    // Inputs present before release only show after the first frame wrap.
    {seg3, seg2, seg1, seg0} = 16'h1234;
    reset = 1'b1;
    push_frame(4'd0, 4'd0, 4'd0, 4'd0, 4*c_RD);
    push_frame(4'd1, 4'd2, 4'd3, 4'd4, 4*c_RD);
    run_check("frame0_zero", 4*c_RD);
    run_check("frame1234_d0", c_RD);

    // Mid-frame input change is deferred to the next frame.
    seg0 = 4'd7;
    run_check("frame1234_rest", 3*c_RD);
    push_frame(4'd1, 4'd2, 4'd3, 4'd7, 4*c_RD);
    run_check("frame1237_a", 6);
    seg1 = 4'hC;
    run_check("frame1237_b", 4*c_RD - 6);
    push_frame(4'd1, 4'd2, 4'hC, 4'd7, 4*c_RD);
    run_check("frame12C7", 4*c_RD);

    // Async reset during digit 2 slot: dark with no clock edge.
    push_frame(4'd1, 4'd2, 4'hC, 4'd7, 2*c_RD + 1);
    run_check("frame12C7_part", 2*c_RD + 1);
    #2 reset = 1'b0;
    #1 check("async_dark", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
    repeat (2) begin
      @(negedge clk);
      check("async_dark_hold", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
    end

    // Restart from digit 0 with a discarded snapshot, then leading-zero case.
    {seg3, seg2, seg1, seg0} = 16'h0500;
    reset = 1'b1;
    push_frame(4'd0, 4'd0, 4'd0, 4'd0, 4*c_RD);
    push_frame(4'd0, 4'd5, 4'd0, 4'd0, 4*c_RD);
    run_check("restart_zero", 4*c_RD);
    run_check("frame0500", 4*c_RD);

    if (r_expq.size() != 0) begin
      n_total++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", r_expq.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
